// File: rtl/mux_arbiter.sv
// mux_arbiter: two-source round-robin arbiter with bounded bursts that owns
// a shared 2:1 mux and registers its output into a single-entry
// valid/ready stage. A word accepted on edge N appears on z_data right
// after edge N. Intended BURST range is 1..15 (cnt is 4 bits wide).

// Plain 2:1 datapath mux shared between the two sources.
module mux #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] z
);

    assign z = sel ? b : a;

endmodule

module mux_arbiter #(
    parameter int WIDTH = 32,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data,
    output logic             z_valid,
    input  logic             z_ready,
    output logic [WIDTH-1:0] z_data,
    output logic             sel,
    output logic             z_src
);

    localparam logic       SRC_A   = 1'b0;
    localparam logic       SRC_B   = 1'b1;
    localparam logic [3:0] BURST_C = 4'(BURST);

    // Arbitration state: who transferred last and how many in a row.
    logic             last_q, last_d;
    logic [3:0]       cnt_q,  cnt_d;
    // Output register and the held mux select.
    logic             z_valid_q, z_valid_d;
    logic [WIDTH-1:0] z_data_q,  z_data_d;
    logic             z_src_q,   z_src_d;
    logic             sel_q;

    logic             grant;
    logic             grant_vld;
    logic             owner_valid;
    logic             can_load;
    logic             xfer;
    logic [WIDTH-1:0] mux_z;

    // Shared datapath; select follows the grant.
    mux #(.WIDTH(WIDTH)) u_mux (
        .a   (a_data),
        .b   (b_data),
        .sel (sel),
        .z   (mux_z)
    );

    assign owner_valid = (last_q == SRC_B) ? b_valid : a_valid;

    // Grant selection: burst lock, then round-robin, then lone requester.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise a path that skips the assignment infers a latch.
        grant     = SRC_A;
        grant_vld = 1'b1;
        if (cnt_q != 4'd0 && cnt_q < BURST_C && owner_valid) begin
            grant = last_q;
        end else if (a_valid && b_valid) begin
            grant = ~last_q;
        end else if (a_valid) begin
            grant = SRC_A;
        end else if (b_valid) begin
            grant = SRC_B;
        end else begin
            grant_vld = 1'b0;
        end
    end

    // With no requester the select keeps its previous value.
    assign sel      = grant_vld ? grant : sel_q;
    assign can_load = !z_valid_q || z_ready;

    // Readys depend only on valids, z_ready and state, never on data;
    // rst_n gates them so nothing is accepted while reset is held.
    assign a_ready = rst_n && grant_vld && (grant == SRC_A) && can_load;
    assign b_ready = rst_n && grant_vld && (grant == SRC_B) && can_load;
    assign xfer    = (a_valid && a_ready) || (b_valid && b_ready);

    // Next-state: load on transfer, drain otherwise; backpressure holds all.
    always_comb begin
        last_d    = last_q;
        cnt_d     = cnt_q;
        z_valid_d = z_valid_q;
        z_data_d  = z_data_q;
        z_src_d   = z_src_q;
        if (xfer) begin
            z_valid_d = 1'b1;
            z_data_d  = mux_z;
            z_src_d   = grant;
            if (grant == last_q && cnt_q < BURST_C) begin
                cnt_d = cnt_q + 4'd1;
            end else begin
                cnt_d  = 4'd1;
                last_d = grant;
            end
        end else if (z_ready) begin
            // Data is left stale; only the valid flag drops.
            z_valid_d = 1'b0;
        end
    end

    // State registers; last resets to B so A wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= SRC_B;
            cnt_q     <= 4'd0;
            z_valid_q <= 1'b0;
            z_data_q  <= '0;
            z_src_q   <= SRC_A;
            sel_q     <= SRC_A;
        end else begin
            // NOTE: registers use non-blocking assignment so every flop
            // samples the pre-edge values regardless of statement order.
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            z_valid_q <= z_valid_d;
            z_data_q  <= z_data_d;
            z_src_q   <= z_src_d;
            sel_q     <= sel;
        end
    end

    assign z_valid = z_valid_q;
    assign z_data  = z_data_q;
    assign z_src   = z_src_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter (WIDTH=32, BURST=4). Stimulus pushes the
// hand-computed word sequence {src, data} into a queue; a monitor pops and
// compares every word the consumer accepts.
module tb_mux_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             a_valid, a_ready;
    logic [WIDTH-1:0] a_data;
    logic             b_valid, b_ready;
    logic [WIDTH-1:0] b_data;
    logic             z_valid, z_ready;
    logic [WIDTH-1:0] z_data;
    logic             sel, z_src;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    mux_arbiter #(.WIDTH(WIDTH), .BURST(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_data  (b_data),
        .z_valid (z_valid),
        .z_ready (z_ready),
        .z_data  (z_data),
        .sel     (sel),
        .z_src   (z_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input logic src, input int data);
        exp_q.push_back({src, 32'(data)});
    endtask

    // One clock: sample handshakes mid-cycle, then advance producers.
    task automatic cycle(output bit af, output bit bf);
        @(negedge clk);
        af = a_valid && a_ready;
        bf = b_valid && b_ready;
        @(posedge clk);
        #1;
        if (af) a_data = a_data + 1;
        if (bf) b_data = b_data - 1;
    endtask

    task automatic drain();
        bit af, bf;
        a_valid = 1'b0;
        b_valid = 1'b0;
        z_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0 && !z_valid) break;
            cycle(af, bf);
        end
        check("drained_queue", exp_q.size(), 0);
        check("drained_valid", z_valid, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: every accepted output word must match the queue head.
    always @(negedge clk) begin
        if (rst_n && z_valid && z_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word actual src=%0d data=%0d required none", z_src, z_data);
            end else begin
                check("z_word", {31'd0, z_src, z_data}, {31'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        bit af, bf;
        // Reset held with both sources valid and consumer ready.
        rst_n   = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 1;
        b_data  = 999;
        z_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_z_valid", z_valid, 0);
        check("rst_z_data", z_data, 0);
        check("rst_z_src", z_src, 0);
        check("rst_sel", sel, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        rst_n = 1'b1;

        // Contention: A x4, B x4, A x4, B x4 with no bubbles.
        for (int i = 0; i < 4; i++) push(0, 1 + i);
        for (int i = 0; i < 4; i++) push(1, 999 - i);
        for (int i = 0; i < 4; i++) push(0, 5 + i);
        for (int i = 0; i < 4; i++) push(1, 995 - i);
        for (int i = 0; i < 16; i++) begin
            cycle(af, bf);
            if (i == 0) check("first_is_a", af, 1);
            check("no_bubble", int'(af) + int'(bf), 1);
        end
        drain();

        // Single source A: same-cycle ready, one-cycle latency, streaming.
        a_valid = 1'b1;
        a_data  = 777;
        for (int i = 0; i < 10; i++) push(0, 777 + i);
        cycle(af, bf);
        check("single_a_ready", af, 1);
        check("single_z_data", z_data, 777);
        check("single_z_src", z_src, 0);
        check("single_z_valid", z_valid, 1);
        for (int i = 1; i < 10; i++) begin
            cycle(af, bf);
            check("stream_a", af, 1);
        end
        drain();

        // Backpressure: two A words, stall 5 cycles, burst resumes at cnt=2.
        do_reset();
        a_valid = 1'b1;
        a_data  = 10;
        push(0, 10);
        push(0, 11);
        cycle(af, bf);
        cycle(af, bf);
        z_ready = 1'b0;
        b_valid = 1'b1;
        b_data  = 500;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_a_ready", a_ready, 0);
            check("bp_b_ready", b_ready, 0);
            check("bp_z_data", z_data, 11);
            check("bp_z_valid", z_valid, 1);
            @(posedge clk);
            #1;
        end
        z_ready = 1'b1;
        push(0, 12);
        push(0, 13);
        push(1, 500);
        push(1, 499);
        push(1, 498);
        for (int i = 0; i < 5; i++) cycle(af, bf);
        drain();

        // Early release: A drops after 2 words, B granted the same cycle.
        do_reset();
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 20;
        b_data  = 600;
        push(0, 20);
        push(0, 21);
        cycle(af, bf);
        cycle(af, bf);
        a_valid = 1'b0;
        push(1, 600);
        cycle(af, bf);
        check("early_b_granted", bf, 1);
        a_valid = 1'b1;
        // B's burst started at 1, so three more B words precede A.
        push(1, 599);
        push(1, 598);
        push(1, 597);
        push(0, 22);
        for (int i = 0; i < 4; i++) cycle(af, bf);
        drain();

        // Asynchronous reset mid-burst with a word held (cnt=3).
        do_reset();
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 30;
        b_data  = 700;
        push(0, 30);
        push(0, 31);
        for (int i = 0; i < 3; i++) cycle(af, bf);
        check("pre_rst_z_valid", z_valid, 1);
        check("pre_rst_z_data", z_data, 32);
        #1 rst_n = 1'b0;
        #1;
        check("async_z_valid", z_valid, 0);
        check("async_z_data", z_data, 0);
        check("async_z_src", z_src, 0);
        check("async_a_ready", a_ready, 0);
        check("async_b_ready", b_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        push(0, 33);
        cycle(af, bf);
        check("post_rst_first_a", af, 1);
        check("post_rst_b_idle", bf, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
